// File: rtl/sme_pkg.sv
// Shared types for the SME job sequencer.
// States, result codes and data widths.
package sme_pkg;
  localparam int CHAR_W = 8;
  localparam int IDX_W  = 5;

  typedef enum logic [2:0] {
    IDLE,
    LOAD,
    SEND,
    WAIT_V,
    RESULT
  } seq_state_t;

  typedef enum logic [1:0] {
    ERR_OK,
    ERR_NOSTR,
    ERR_TIMEOUT,
    ERR_OVF
  } res_err_t;
endpackage

// File: rtl/sme_job_sequencer_if.sv
// Host byte stream, SME drive and result channel.
// master = host/environment side, slave = sequencer.
interface sme_job_sequencer_if;
  import sme_pkg::*;

  logic              in_valid;
  logic              in_ready;
  logic [CHAR_W-1:0] in_char;
  logic              in_type;
  logic              in_last;

  logic [CHAR_W-1:0] sme_chardata;
  logic              sme_isstring;
  logic              sme_ispattern;
  logic              sme_valid;
  logic              sme_match;
  logic [IDX_W-1:0]  sme_index;

  logic              res_valid;
  logic              res_ready;
  logic              res_match;
  logic [IDX_W-1:0]  res_index;
  logic [7:0]        res_tag;
  res_err_t          res_err;

  modport master (
    output in_valid, in_char, in_type, in_last,
    output sme_valid, sme_match, sme_index,
    output res_ready,
    input  in_ready,
    input  sme_chardata, sme_isstring, sme_ispattern,
    input  res_valid, res_match, res_index, res_tag, res_err
  );

  modport slave (
    input  in_valid, in_char, in_type, in_last,
    input  sme_valid, sme_match, sme_index,
    input  res_ready,
    output in_ready,
    output sme_chardata, sme_isstring, sme_ispattern,
    output res_valid, res_match, res_index, res_tag, res_err
  );
endinterface

// File: rtl/sme_char_buf.sv
// Character buffer with write/read pointers.
// Writes beyond DEPTH are dropped and flagged as overflow.
module sme_char_buf
  import sme_pkg::*;
#(
  parameter  int DEPTH = 32,
  localparam int PW    = $clog2(DEPTH) + 1
) (
  input  logic              clk,
  input  logic              reset_n,
  input  logic              clr,
  input  logic              wr,
  input  logic [CHAR_W-1:0] wr_data,
  input  logic              rd,
  output logic [CHAR_W-1:0] rd_data,
  output logic              more,
  output logic              ovf
);
  logic [CHAR_W-1:0] mem [DEPTH];
  logic [PW-1:0]     len;
  logic [PW-1:0]     rd_ptr;
  logic [PW-1:0]     wa;
  logic              ovf_q;
  logic              full;

  assign full    = (len == PW'(DEPTH));
  assign wa      = clr ? '0 : len;
  assign rd_data = mem[rd_ptr[PW-2:0]];
  assign more    = (rd_ptr != len);
  // Includes the char being written this cycle.
  assign ovf     = !clr && (ovf_q || (wr && full));

  always_ff @(posedge clk or negedge reset_n) begin
    if (!reset_n) begin
      for (int i = 0; i < DEPTH; i++) mem[i] <= '0;
      len    <= '0;
      rd_ptr <= '0;
      ovf_q  <= 1'b0;
    end else begin
      if (wr && (clr || !full)) mem[wa[PW-2:0]] <= wr_data;
      if (clr) len <= PW'(wr);
      else if (wr && !full) len <= len + PW'(1);
      rd_ptr <= clr ? PW'(rd) : rd_ptr + PW'(rd);
      if (clr) ovf_q <= 1'b0;
      else if (wr && full) ovf_q <= 1'b1;
    end
  end
endmodule

// File: rtl/sme_job_sequencer.sv
// Buffers host string/pattern jobs and replays them to SME
// as gap-free bursts, then returns one result per pattern.
module sme_job_sequencer
  import sme_pkg::*;
#(
  parameter int STR_DEPTH = 32,
  parameter int PAT_DEPTH = 8,
  parameter int TIMEOUT   = 1023
) (
  input logic               clk,
  input logic               reset_n,
  sme_job_sequencer_if.slave bus
);
  localparam int CW = $clog2(TIMEOUT + 1);

  seq_state_t        state;
  logic              job_pat;
  logic              str_loaded;
  logic [7:0]        tag;
  logic [CW-1:0]     wcnt;

  logic              acc, first, typ, done;
  logic              s_rd, p_rd, s_more, p_more, s_ovf, p_ovf;
  logic              ovf_cur, nostr, go_send;
  logic [CHAR_W-1:0] s_data, p_data, cur_rd;

  assign acc     = bus.in_valid && bus.in_ready;
  assign first   = acc && (state == IDLE);
  assign typ     = first ? bus.in_type : job_pat;
  assign done    = acc && bus.in_last;
  assign ovf_cur = typ ? p_ovf : s_ovf;
  assign nostr   = typ && !str_loaded && !ovf_cur;
  assign go_send = done && !ovf_cur && !nostr;
  assign cur_rd  = job_pat ? p_data : s_data;

  assign s_rd = (go_send && !typ) ||
                (state == SEND && !job_pat && s_more);
  assign p_rd = (go_send && typ) ||
                (state == SEND && job_pat && p_more);

  sme_char_buf #(.DEPTH(STR_DEPTH)) u_str (
    .clk     (clk),
    .reset_n (reset_n),
    .clr     (first && !bus.in_type),
    .wr      (acc && !typ),
    .wr_data (bus.in_char),
    .rd      (s_rd),
    .rd_data (s_data),
    .more    (s_more),
    .ovf     (s_ovf)
  );

  sme_char_buf #(.DEPTH(PAT_DEPTH)) u_pat (
    .clk     (clk),
    .reset_n (reset_n),
    .clr     (first && bus.in_type),
    .wr      (acc && typ),
    .wr_data (bus.in_char),
    .rd      (p_rd),
    .rd_data (p_data),
    .more    (p_more),
    .ovf     (p_ovf)
  );

  always_ff @(posedge clk or negedge reset_n) begin
    if (!reset_n) begin
      state             <= IDLE;
      job_pat           <= 1'b0;
      str_loaded        <= 1'b0;
      tag               <= '0;
      wcnt              <= '0;
      bus.in_ready      <= 1'b0;
      bus.sme_chardata  <= '0;
      bus.sme_isstring  <= 1'b0;
      bus.sme_ispattern <= 1'b0;
      bus.res_valid     <= 1'b0;
      bus.res_match     <= 1'b0;
      bus.res_index     <= '0;
      bus.res_tag       <= '0;
      bus.res_err       <= ERR_OK;
    end else begin
      case (state)
        IDLE, LOAD: begin
          bus.in_ready <= 1'b1;
          if (first) job_pat <= bus.in_type;
          if (done) begin
            bus.in_ready <= 1'b0;
            unique case (1'b1)
              ovf_cur: begin
                state         <= RESULT;
                bus.res_valid <= 1'b1;
                bus.res_err   <= ERR_OVF;
                bus.res_tag   <= tag;
                if (!typ) str_loaded <= 1'b0;
              end
              nostr: begin
                state         <= RESULT;
                bus.res_valid <= 1'b1;
                bus.res_err   <= ERR_NOSTR;
                bus.res_tag   <= tag;
              end
              go_send: begin
                // A single-char job has not reached the buffer yet.
                state             <= SEND;
                bus.sme_chardata  <= first ? bus.in_char : cur_rd;
                bus.sme_isstring  <= !typ;
                bus.sme_ispattern <= typ;
              end
              default: state <= state;
            endcase
          end else if (first) begin
            state <= LOAD;
          end
        end
        SEND: begin
          if (job_pat ? p_more : s_more) begin
            bus.sme_chardata <= cur_rd;
          end else begin
            bus.sme_chardata  <= '0;
            bus.sme_isstring  <= 1'b0;
            bus.sme_ispattern <= 1'b0;
            if (job_pat) begin
              state <= WAIT_V;
              wcnt  <= '0;
            end else begin
              state        <= IDLE;
              str_loaded   <= 1'b1;
              tag          <= '0;
              bus.in_ready <= 1'b1;
            end
          end
        end
        WAIT_V: begin
          if (bus.sme_valid) begin
            state         <= RESULT;
            bus.res_valid <= 1'b1;
            bus.res_match <= bus.sme_match;
            bus.res_index <= bus.sme_match ? bus.sme_index : '0;
            bus.res_err   <= ERR_OK;
            bus.res_tag   <= tag;
          end else if (wcnt == CW'(TIMEOUT - 1)) begin
            // Counter would reach TIMEOUT: TIMEOUT cycles spent here.
            state         <= RESULT;
            bus.res_valid <= 1'b1;
            bus.res_match <= 1'b0;
            bus.res_index <= '0;
            bus.res_err   <= ERR_TIMEOUT;
            bus.res_tag   <= tag;
          end else begin
            wcnt <= wcnt + CW'(1);
          end
        end
        RESULT: begin
          if (bus.res_ready) begin
            state         <= IDLE;
            tag           <= tag + 8'd1;
            bus.in_ready  <= 1'b1;
            bus.res_valid <= 1'b0;
            bus.res_match <= 1'b0;
            bus.res_index <= '0;
            bus.res_tag   <= '0;
            bus.res_err   <= ERR_OK;
          end
        end
        default: state <= IDLE;
      endcase
    end
  end
endmodule

// File: tb/tb_sme_job_sequencer.sv
// Directed bench for sme_job_sequencer with a small
// behavioural SME model that searches the loaded string.
module tb_sme_job_sequencer;
  localparam int TO = 1023;

  logic clk = 1'b0;
  logic reset_n = 1'b0;
  always #5 clk = ~clk;

  sme_job_sequencer_if bus ();

  sme_job_sequencer #(
    .STR_DEPTH (32),
    .PAT_DEPTH (8),
    .TIMEOUT   (TO)
  ) dut (
    .clk     (clk),
    .reset_n (reset_n),
    .bus     (bus)
  );

  int tests = 0;
  int fails = 0;

  // SME model state
  string m_str = "";
  string m_pat = "";
  bit    prev_s, prev_p;
  bit    sme_en = 1'b1;
  int    pend = 0;
  int    s_cyc, s_rise, p_cyc, p_rise;
  int    viol = 0;

  always @(negedge clk) begin
    bus.sme_valid = 1'b0;
    if (!reset_n) begin
      prev_s        = 1'b0;
      prev_p        = 1'b0;
      pend          = 0;
      bus.sme_match = 1'b0;
      bus.sme_index = '0;
    end else begin
      if (bus.sme_isstring && bus.sme_ispattern) viol++;
      if (!bus.sme_isstring && !bus.sme_ispattern &&
          bus.sme_chardata != 8'd0) viol++;
      if (bus.sme_isstring) begin
        if (!prev_s) begin m_str = ""; s_rise++; end
        m_str = $sformatf("%s%c", m_str, bus.sme_chardata);
        s_cyc++;
      end
      if (bus.sme_ispattern) begin
        if (!prev_p) begin m_pat = ""; p_rise++; end
        m_pat = $sformatf("%s%c", m_pat, bus.sme_chardata);
        p_cyc++;
      end
      if (prev_p && !bus.sme_ispattern && sme_en) begin
        pend = 3;
      end else if (pend > 0) begin
        pend--;
        if (pend == 0) begin
          bit hit;
          int at;
          hit = 1'b0;
          at  = 0;
          for (int i = 0; i + m_pat.len() <= m_str.len(); i++)
            if (!hit && m_str.substr(i, i + m_pat.len() - 1) == m_pat) begin
              hit = 1'b1;
              at  = i;
            end
          bus.sme_valid = 1'b1;
          bus.sme_match = hit;
          bus.sme_index = 5'(at);
        end
      end
      prev_s = bus.sme_isstring;
      prev_p = bus.sme_ispattern;
    end
  end

  task automatic chk(input string name, input int act, input int exp);
    tests++;
    if (act != exp) begin
      fails++;
      $display("FAIL %s: got %0d expected %0d", name, act, exp);
    end
  endtask

  task automatic chk_str(input string name, input string act, input string exp);
    tests++;
    if (act != exp) begin
      fails++;
      $display("FAIL %s: got \"%s\" expected \"%s\"", name, act, exp);
    end
  endtask

  task automatic clr_cnt();
    s_cyc = 0; s_rise = 0; p_cyc = 0; p_rise = 0;
  endtask

  task automatic send_job(input string s, input bit typ,
                          input bit gap, input bit flip);
    int t;
    for (int i = 0; i < s.len(); i++) begin
      if (gap && (i % 2 == 1)) begin
        bus.in_valid = 1'b0;
        @(negedge clk);
      end
      bus.in_valid = 1'b1;
      bus.in_char  = s[i];
      bus.in_type  = (flip && i > 0) ? !typ : typ;
      bus.in_last  = (i == s.len() - 1);
      t = 0;
      while (!bus.in_ready && t < 2000) begin
        @(negedge clk);
        t++;
      end
      if (t >= 2000) chk("in_ready_wait", 0, 1);
      @(negedge clk);
    end
    bus.in_valid = 1'b0;
    bus.in_last  = 1'b0;
  endtask

  task automatic wait_ready();
    int t = 0;
    while (!bus.in_ready && t < 200) begin
      @(negedge clk);
      t++;
    end
    chk("idle_ready", int'(bus.in_ready), 1);
  endtask

  task automatic wait_res();
    int t = 0;
    while (!bus.res_valid && t < 3000) begin
      @(negedge clk);
      t++;
    end
    chk("res_valid_seen", int'(bus.res_valid), 1);
  endtask

  task automatic chk_res(input string n, input int m, input int idx,
                         input int tg, input int err);
    chk({n, "_match"}, int'(bus.res_match), m);
    chk({n, "_index"}, int'(bus.res_index), idx);
    chk({n, "_tag"}, int'(bus.res_tag), tg);
    chk({n, "_err"}, int'(bus.res_err), err);
  endtask

  task automatic take_res();
    bus.res_ready = 1'b1;
    @(negedge clk);
    bus.res_ready = 1'b0;
    chk("res_valid_drop", int'(bus.res_valid), 0);
  endtask

  task automatic do_reset(input bit check);
    reset_n       = 1'b0;
    bus.in_valid  = 1'b0;
    bus.in_char   = '0;
    bus.in_type   = 1'b0;
    bus.in_last   = 1'b0;
    bus.res_ready = 1'b0;
    repeat (3) @(negedge clk);
    if (check) begin
      chk("rst_in_ready", int'(bus.in_ready), 0);
      chk("rst_isstring", int'(bus.sme_isstring), 0);
      chk("rst_ispattern", int'(bus.sme_ispattern), 0);
      chk("rst_chardata", int'(bus.sme_chardata), 0);
      chk("rst_res_valid", int'(bus.res_valid), 0);
      chk("rst_res_err", int'(bus.res_err), 0);
    end
    reset_n = 1'b1;
    @(negedge clk);
    chk("post_rst_ready", int'(bus.in_ready), 1);
  endtask

  typedef struct {
    string chars;
    bit    typ;
    bit    gap;
    bit    flip;
    bit    has_res;
    int    m;
    int    idx;
    int    tag;
    int    err;
    int    s_cyc;
    int    p_cyc;
  } vec_t;

  vec_t v[12];

  initial begin
    string s32;
    int    t, n;
    s32 = "abcdefghijklmnopqrstuvwxyz012345";
    //        chars     typ gap flip res m idx tag err s  p
    v[0]  = '{"abcabd",    0, 1, 0, 0, 0, 0, 0, 0, 6, 0};
    v[1]  = '{"cab",       1, 0, 0, 1, 1, 2, 0, 0, 0, 3};
    v[2]  = '{"abcabd",    0, 0, 0, 0, 0, 0, 0, 0, 6, 0};
    v[3]  = '{"xyz",       1, 0, 1, 1, 0, 0, 0, 0, 0, 3};
    v[4]  = '{"abd",       1, 1, 0, 1, 1, 3, 1, 0, 0, 3};
    v[5]  = '{"a",         1, 0, 0, 1, 1, 0, 2, 0, 0, 1};
    v[6]  = '{"abcabdab",  1, 0, 0, 1, 0, 0, 3, 0, 0, 8};
    v[7]  = '{"abcdefghi", 1, 0, 0, 1, 0, 0, 4, 3, 0, 0};
    v[8]  = '{s32,         0, 0, 0, 0, 0, 0, 0, 0, 32, 0};
    v[9]  = '{"2345",      1, 0, 0, 1, 1, 28, 0, 0, 0, 4};
    v[10] = '{{s32, "6"},  0, 0, 0, 1, 0, 0, 1, 3, 0, 0};
    v[11] = '{"ab",        1, 0, 0, 1, 0, 0, 2, 1, 0, 0};

    do_reset(1'b1);

    for (int k = 0; k < 12; k++) begin
      string nm;
      nm = $sformatf("v%0d", k);
      clr_cnt();
      send_job(v[k].chars, v[k].typ, v[k].gap, v[k].flip);
      if (v[k].has_res) begin
        wait_res();
        chk_res(nm, v[k].m, v[k].idx, v[k].tag, v[k].err);
        take_res();
      end else begin
        wait_ready();
      end
      chk({nm, "_s_cyc"}, s_cyc, v[k].s_cyc);
      chk({nm, "_p_cyc"}, p_cyc, v[k].p_cyc);
      if (v[k].s_cyc > 0) begin
        chk({nm, "_s_rise"}, s_rise, 1);
        chk_str({nm, "_s_data"}, m_str, v[k].chars);
      end
      if (v[k].p_cyc > 0) begin
        chk({nm, "_p_rise"}, p_rise, 1);
        chk_str({nm, "_p_data"}, m_pat, v[k].chars);
      end
    end

    // Pattern straight after reset: no string loaded
    do_reset(1'b0);
    clr_cnt();
    send_job("ab", 1'b1, 1'b0, 1'b0);
    wait_res();
    chk_res("nostr", 0, 0, 0, 1);
    take_res();
    chk("nostr_p_cyc", p_cyc, 0);

    // SME never answers: timeout result
    send_job("abcabd", 1'b0, 1'b0, 1'b0);
    wait_ready();
    sme_en = 1'b0;
    clr_cnt();
    send_job("ab", 1'b1, 1'b0, 1'b0);
    t = 0;
    while (!bus.sme_ispattern && t < 50) begin @(negedge clk); t++; end
    while (bus.sme_ispattern && t < 50) begin @(negedge clk); t++; end
    n = 0;
    while (!bus.res_valid && n < 3000) begin @(negedge clk); n++; end
    chk("to_cycles", n, TO);
    chk_res("to", 0, 0, 0, 2);
    take_res();
    sme_en = 1'b1;
    send_job("bc", 1'b1, 1'b0, 1'b0);
    wait_res();
    chk_res("after_to", 1, 1, 1, 0);
    take_res();

    // Result held while res_ready stays low
    send_job("ca", 1'b1, 1'b0, 1'b0);
    wait_res();
    for (int c = 0; c < 5; c++) begin
      chk("hold_valid", int'(bus.res_valid), 1);
      chk("hold_in_ready", int'(bus.in_ready), 0);
      chk_res("hold", 1, 2, 2, 0);
      @(negedge clk);
    end
    take_res();

    // Asynchronous reset in the middle of a string burst
    send_job("abcdefgh", 1'b0, 1'b0, 1'b0);
    t = 0;
    while (!bus.sme_isstring && t < 50) begin @(negedge clk); t++; end
    chk("burst_started", int'(bus.sme_isstring), 1);
    @(negedge clk);
    #2 reset_n = 1'b0;
    #1;
    chk("arst_isstring", int'(bus.sme_isstring), 0);
    chk("arst_ispattern", int'(bus.sme_ispattern), 0);
    chk("arst_chardata", int'(bus.sme_chardata), 0);
    chk("arst_in_ready", int'(bus.in_ready), 0);
    repeat (2) @(negedge clk);
    reset_n = 1'b1;
    @(negedge clk);
    chk("arst_release_ready", int'(bus.in_ready), 1);
    clr_cnt();
    send_job("ab", 1'b1, 1'b0, 1'b0);
    wait_res();
    chk_res("arst_nostr", 0, 0, 0, 1);
    take_res();
    chk("arst_p_cyc", p_cyc, 0);

    chk("protocol_viol", viol, 0);

    $display("[TB] %0d tests run, %0d failed", tests, fails);
    $finish;
  end

  initial begin
    #500000;
    $display("FAIL watchdog: simulation time limit reached");
    $fatal(1);
  end
endmodule
